// File: rtl/moore_pulse_monitor.sv
// moore_pulse_monitor: checks a periodic one-cycle pulse stream for lock, early/late/wide pulses
module moore_pulse_monitor #(
  parameter int PERIOD = 4,
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_out
);
  localparam int GW = $clog2(PERIOD + 1);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0] PER = GW'(PERIOD);
  localparam logic [CW-1:0] LCK = CW'(LOCK_COUNT);
  localparam logic [GW-1:0] ONE = GW'(1);
  typedef enum logic [1:0] {IDLE = 2'b00, TRACK = 2'b01, LOCKED = 2'b10, FAULT = 2'b11} state_t;
  state_t state, state_n;
  logic [GW-1:0] gap, gap_n;
  logic [CW-1:0] good, good_n;
  logic on_time, bad;
  always_comb begin
    on_time = in && gap == PER;
    bad = (in && gap < PER) || (!in && gap == PER);
    state_n = state;
    gap_n = gap;
    good_n = good;
    case (state)
      IDLE: begin
        state_n = in ? TRACK : IDLE;
        gap_n = in ? ONE : '0;
        good_n = '0;
      end
      TRACK: begin
        good_n = on_time ? good + 1'b1 : good;
        gap_n = on_time ? ONE : gap + 1'b1;
        state_n = bad ? FAULT : (on_time && good_n == LCK) ? LOCKED : TRACK;
      end
      LOCKED: begin
        gap_n = on_time ? ONE : gap + 1'b1;
        state_n = bad ? FAULT : LOCKED;
      end
      FAULT: begin
        state_n = in ? TRACK : IDLE;
        gap_n = in ? ONE : '0;
        good_n = '0;
      end
      default: begin
        state_n = IDLE;
        gap_n = '0;
        good_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gap <= '0;
      good <= '0;
      err_count <= '0;
    end else begin
      state <= state_n;
      gap <= gap_n;
      good <= good_n;
      if (state_n == FAULT && err_count != '1) err_count <= err_count + 1'b1;
    end
  end
  assign locked = state == LOCKED;
  assign err_pulse = state == FAULT;
  assign state_out = state;
endmodule

// File: tb/tb_moore_pulse_monitor.sv
// tb_moore_pulse_monitor: directed checks of lock, faults, saturation and reset priority
module tb_moore_pulse_monitor;
  logic clk, reset, in;
  logic locked, err_pulse, locked2, err_pulse2;
  logic [7:0] err_count;
  logic [1:0] err_count2, state_out, state_out2;
  int checks = 0;
  int errors = 0;
  moore_pulse_monitor #(.PERIOD(4), .LOCK_COUNT(3), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .in(in), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .state_out(state_out)
  );
  moore_pulse_monitor #(.PERIOD(4), .LOCK_COUNT(3), .ERR_W(2)) dut2 (
    .clk(clk), .reset(reset), .in(in), .locked(locked2), .err_pulse(err_pulse2),
    .err_count(err_count2), .state_out(state_out2)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic step(input logic v);
    in = v;
    @(posedge clk);
    #1;
  endtask
  task automatic period_pulse();
    step(0);
    step(0);
    step(0);
    step(1);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [1:0] st, input logic lk, input logic ep, input logic [7:0] ec);
    chk({tag, "_state"}, 32'(state_out), 32'(st));
    chk({tag, "_locked"}, 32'(locked), 32'(lk));
    chk({tag, "_err_pulse"}, 32'(err_pulse), 32'(ep));
    chk({tag, "_err_count"}, 32'(err_count), 32'(ec));
  endtask
  initial begin
    reset = 1;
    in = 0;
    step(0);
    step(0);
    chk_all("reset", 2'b00, 0, 0, 0);
    reset = 0;
    step(0);
    chk_all("idle", 2'b00, 0, 0, 0);
    step(1);
    chk_all("first_pulse", 2'b01, 0, 0, 0);
    period_pulse();
    chk_all("ontime1", 2'b01, 0, 0, 0);
    period_pulse();
    chk_all("ontime2", 2'b01, 0, 0, 0);
    period_pulse();
    chk_all("lock", 2'b10, 1, 0, 0);
    step(0);
    step(0);
    chk_all("locked_hold", 2'b10, 1, 0, 0);
    step(1);
    chk_all("early_fault", 2'b11, 0, 1, 1);
    step(0);
    chk_all("early_idle", 2'b00, 0, 0, 1);
    step(1);
    period_pulse();
    period_pulse();
    period_pulse();
    chk_all("relock", 2'b10, 1, 0, 1);
    step(0);
    step(0);
    step(0);
    chk_all("await_pulse", 2'b10, 1, 0, 1);
    step(0);
    chk_all("missing_fault", 2'b11, 0, 1, 2);
    step(0);
    chk_all("missing_idle", 2'b00, 0, 0, 2);
    step(1);
    period_pulse();
    period_pulse();
    period_pulse();
    chk_all("relock2", 2'b10, 1, 0, 2);
    reset = 1;
    step(1);
    chk_all("reset_midlock", 2'b00, 0, 0, 0);
    reset = 0;
    step(1);
    chk_all("reset_in_high", 2'b01, 0, 0, 0);
    period_pulse();
    period_pulse();
    chk_all("relock_track", 2'b01, 0, 0, 0);
    period_pulse();
    chk_all("relock_after_reset", 2'b10, 1, 0, 0);
    reset = 1;
    step(0);
    reset = 0;
    step(1);
    chk_all("wide_first", 2'b01, 0, 0, 0);
    step(1);
    chk_all("wide_fault", 2'b11, 0, 1, 1);
    step(1);
    chk_all("fault_pulse_track", 2'b01, 0, 0, 1);
    period_pulse();
    chk_all("fault_pulse_ontime", 2'b01, 0, 0, 1);
    reset = 1;
    step(0);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      step(1);
      chk("sat_fault_state", 32'(state_out2), 32'(2'b11));
      chk("sat_count_w2", 32'(err_count2), 32'((i + 1) > 3 ? 3 : i + 1));
      chk("sat_count_w8", 32'(err_count), 32'(i + 1));
      step(0);
      chk("sat_idle", 32'(state_out2), 32'(2'b00));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
